// File: rtl/mem_reader_pkg.sv
// Shared types and derived widths for the mem_reader block.
package mem_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH_DEFAULT = 4;

  function automatic int log_fifo_depth(input int depth);
    return $clog2(depth);
  endfunction

  localparam int LOG_FIFO_DEPTH = log_fifo_depth(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/mem_reader_fifo.sv
// First-word-fall-through response FIFO; head is valid whenever !empty.
module mem_reader_fifo
  import mem_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          head,
  output logic [$clog2(FIFO_DEPTH):0]    count,
  output logic                           empty,
  output logic                           full
);
  localparam int LW = log_fifo_depth(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0]         wptr, rptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (LW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (LW+1)'(do_push) - (LW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/mem_reader.sv
// Burst read sequencer: issues credit-limited reads and streams responses out.
// Define MEM_READER_DEBUG_EN for a cycle counter with transfer/done trace.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 16,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LOG_MAX_ADDRESS-1:0] base_addr,
  input  logic [LOG_MAX_ADDRESS:0]   num_words,
  output logic                       busy,
  output logic                       done,
  output logic [LOG_MAX_ADDRESS-1:0] mem_addr_read,
  output logic                       mem_read,
  input  logic [DATA_WIDTH-1:0]      mem_data_read,
  input  logic                       mem_valid_out,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready
);
  localparam int AW = LOG_MAX_ADDRESS;
  localparam int CW = log_fifo_depth(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [AW:0]   issue_cnt, ret_cnt, ret_nxt;
  logic [CW-1:0] inflight, fifo_count;
  logic          credit, wr, pop, fifo_empty, fifo_full;

  assign pop           = out_valid && out_ready;
  // Responses with nothing in flight are stale (e.g. issued before a reset).
  assign wr            = mem_valid_out && (inflight != '0);
  assign credit        = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_S;
  assign ret_nxt       = (pop && ret_cnt != '0) ? ret_cnt - ONE_W : ret_cnt;
  assign mem_addr_read = addr;
  assign out_valid     = !fifo_empty;

  mem_reader_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr && (!fifo_full || pop)),
    .push_data (mem_data_read),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && num_words != '0) state_nxt = READ;
      READ:    if (mem_read && issue_cnt == ONE_W) state_nxt = DRAIN;
      DRAIN:   if (ret_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    mem_read = (state == READ) && (issue_cnt != '0) && credit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      inflight  <= '0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= inflight + CW'(mem_read) - CW'(wr);
      if (state == IDLE && start) begin
        addr      <= base_addr;
        issue_cnt <= num_words;
        ret_cnt   <= num_words;
        done      <= (num_words == '0);
      end else begin
        if (mem_read) begin
          addr      <= addr + 1'b1;
          issue_cnt <= issue_cnt - ONE_W;
        end
        ret_cnt <= ret_nxt;
        // Registered so done lands in the cycle right after the last transfer.
        if (state == DRAIN && ret_nxt == '0) done <= 1'b1;
      end
    end
  end

`ifdef MEM_READER_DEBUG_EN
  logic [15:0]   tics;
  logic [AW-1:0] out_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      tics     <= '0;
      out_addr <= '0;
    end else begin
      tics <= tics + 16'd1;
      if (state == IDLE && start) out_addr <= base_addr;
      else if (pop)               out_addr <= out_addr + 1'b1;
      if (pop)
        $display("MEM_READER: cycle %d addr %x data %x", tics, out_addr, out_data);
      if (done)
        $display("MEM_READER: cycle %d addr %x data %x", tics, out_addr, out_data);
      if (wr && !pop && fifo_count == CW'(FIFO_DEPTH))
        $error("MEM_READER: response FIFO overflow at cycle %d", tics);
    end
  end
`endif

endmodule

// File: tb/tb_mem_reader.sv
// Directed + randomized bench for mem_reader against a burst-level reference model.
module tb_mem_reader;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic          busy, done, mem_read, out_valid;
  logic          mem_valid_out = 1'b0;
  logic [AW-1:0] base_addr = '0, mem_addr_read;
  logic [AW:0]   num_words = '0;
  logic [DW-1:0] mem_data_read = '0, out_data;

  int checks = 0, errors = 0;
  logic [DW-1:0] got_data[$];
  logic [AW-1:0] got_addr[$];
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;

  mem_reader #(.DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .mem_addr_read(mem_addr_read), .mem_read(mem_read),
    .mem_data_read(mem_data_read), .mem_valid_out(mem_valid_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Memory with registered read, contents mem[i] = i[7:0].
  always @(posedge clk) begin
    mem_valid_out <= mem_read;
    mem_data_read <= mem_addr_read[DW-1:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream/issue monitor: records traffic, checks hold stability and credit limit.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
      end
      if (got_addr.size() - got_data.size() >= FD)
        chk("credit_stall", 32'(mem_read), 32'd0);
      if (mem_read) got_addr.push_back(mem_addr_read);
      if (out_valid && out_ready) got_data.push_back(out_data);
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // mode 0: ready=1, 1: toggle, 2: random, 3: random plus a start pulse while busy
  task automatic burst(input logic [AW-1:0] b, input int n, input int mode, input string tag);
    int c, done_cyc, first_v;
    logic busy_seen, prev_x, last_prev_x;
    logic [AW-1:0] ea;
    got_data.delete();
    got_addr.delete();
    start = 1'b1; base_addr = b; num_words = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1; done_cyc = -1; first_v = -1;
    busy_seen = 1'b0; prev_x = 1'b0; last_prev_x = 1'b0;
    while (done_cyc < 0 && c < 2000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = c[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 3) begin
        start = (c == 4);
        base_addr = 16'h1234;
        num_words = 17'd3;
      end
      @(negedge clk);
      busy_seen = busy_seen | busy;
      if (first_v < 0 && out_valid) first_v = c;
      if (done) begin
        done_cyc = c;
        last_prev_x = prev_x;
      end
      prev_x = out_valid && out_ready;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cyc > 0), 32'd1);
    chk({tag, "_nwords"}, 32'(got_data.size()), 32'(n));
    chk({tag, "_naddr"}, 32'(got_addr.size()), 32'(n));
    for (int k = 0; k < n && k < got_data.size() && k < got_addr.size(); k++) begin
      ea = b + AW'(k);
      chk({tag, "_addr"}, 32'(got_addr[k]), 32'(ea));
      chk({tag, "_data"}, 32'(got_data[k]), 32'(ea[DW-1:0]));
    end
    if (n == 0) begin
      chk({tag, "_busy_never"}, 32'(busy_seen), 32'd0);
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd1);
    end else begin
      chk({tag, "_done_after_xfer"}, 32'(last_prev_x), 32'd1);
    end
    if (mode == 0 && n > 0) begin
      chk({tag, "_first_valid"}, 32'(first_v), 32'd3);
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(n + 3));
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_addr", 32'(mem_addr_read), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    burst(16'h0010, 4, 0, "basic");
    burst(16'h0100, 8, 1, "bp");
    burst(16'hFFFE, 4, 0, "wrap");
    burst(16'h0555, 0, 0, "zero");
    burst(16'h7FFF, 1, 0, "single");
    burst(16'h0200, 6, 3, "start_busy");

    // Reset two words into a 16-word burst.
    got_data.delete();
    got_addr.delete();
    start = 1'b1; base_addr = 16'h0300; num_words = 17'd16; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (got_data.size() < 2 && w < 50) begin
      @(negedge clk);
      @(posedge clk); #1;
      w++;
    end
    chk("midrst_two_words", 32'(got_data.size() >= 2), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_addr", 32'(mem_addr_read), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_stale_dropped", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    burst(16'h0040, 2, 0, "post_rst");

    for (int i = 0; i < 6; i++) begin
      burst(AW'($urandom), int'($urandom_range(1, 12)), 2, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
